// File: rtl/mult_sequencer.sv
// mult_sequencer: request/response controller for an 8-bit sign-magnitude
// shift-add multiplier. It accepts an operand pair and holds it on the
// multiplier inputs. It pulses the multiplier's load/clear phase, then lets
// it run until done or until the watchdog expires. The result is held until
// the consumer takes it.
//
// Ports
//   clock, reset                     rising-edge clock, async active-high reset
//   req_valid / req_ready            operand handshake (ready only in IDLE)
//   multiplier_in, multiplicand_in   sign-magnitude operands, bit7 = sign
//   mul_start                        1 = load/clear multiplier, 0 = run
//   mul_multiplier, mul_multiplicand registered operands to the multiplier
//   mul_done, mul_result             multiplier done flag and product magnitude
//   rsp_valid / rsp_ready            response handshake
//   rsp_result, rsp_negative         captured magnitude and sign
//   rsp_timeout                      response came from the watchdog (result 0)
//   busy                             high in every state except IDLE
module mult_sequencer #(
   parameter int unsigned LOAD_CYCLES    = 1,
   parameter int unsigned MAX_RUN_CYCLES = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  multiplier_in,
   input  logic [7:0]  multiplicand_in,
   output logic        mul_start,
   output logic [7:0]  mul_multiplier,
   output logic [7:0]  mul_multiplicand,
   input  logic        mul_done,
   input  logic [13:0] mul_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [13:0] rsp_result,
   output logic        rsp_negative,
   output logic        rsp_timeout,
   output logic        busy
);

   localparam int unsigned OP_W       = 8;
   localparam int unsigned RES_W      = 14;
   localparam int unsigned LOAD_CNT_W = $clog2(LOAD_CYCLES + 1);
   localparam int unsigned RUN_CNT_W  = $clog2(MAX_RUN_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [LOAD_CNT_W-1:0] load_cnt, load_cnt_nxt;
   logic [RUN_CNT_W-1:0]  run_cnt, run_cnt_nxt;
   logic [OP_W-1:0]       op_a_nxt, op_b_nxt;
   logic [RES_W-1:0]      rsp_result_nxt;
   logic                  rsp_valid_nxt, rsp_negative_nxt, rsp_timeout_nxt;
   logic                  mul_start_nxt, req_ready_nxt, busy_nxt;

   // State and all outputs are registered; their next values come from the
   // combinational block below.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         load_cnt         <= '0;
         run_cnt          <= '0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
         mul_start        <= 1'b1;
         req_ready        <= 1'b1;
         busy             <= 1'b0;
         rsp_valid        <= 1'b0;
         rsp_result       <= '0;
         rsp_negative     <= 1'b0;
         rsp_timeout      <= 1'b0;
      end else begin
         state            <= state_nxt;
         load_cnt         <= load_cnt_nxt;
         run_cnt          <= run_cnt_nxt;
         mul_multiplier   <= op_a_nxt;
         mul_multiplicand <= op_b_nxt;
         mul_start        <= mul_start_nxt;
         req_ready        <= req_ready_nxt;
         busy             <= busy_nxt;
         rsp_valid        <= rsp_valid_nxt;
         rsp_result       <= rsp_result_nxt;
         rsp_negative     <= rsp_negative_nxt;
         rsp_timeout      <= rsp_timeout_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt        = state;
      load_cnt_nxt     = load_cnt;
      run_cnt_nxt      = run_cnt;
      op_a_nxt         = mul_multiplier;
      op_b_nxt         = mul_multiplicand;
      rsp_valid_nxt    = rsp_valid;
      rsp_result_nxt   = rsp_result;
      rsp_negative_nxt = rsp_negative;
      rsp_timeout_nxt  = rsp_timeout;

      unique case (state)
         IDLE: begin
            if (req_valid) begin
               op_a_nxt     = multiplier_in;
               op_b_nxt     = multiplicand_in;
               load_cnt_nxt = '0;
               run_cnt_nxt  = '0;
               state_nxt    = LOAD;
            end
         end
         LOAD: begin
            // mul_done is meaningless while the multiplier is being cleared.
            load_cnt_nxt = load_cnt + LOAD_CNT_W'(1);
            if (load_cnt == LOAD_CNT_W'(LOAD_CYCLES - 1)) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            run_cnt_nxt = run_cnt + RUN_CNT_W'(1);
            // Done wins over the watchdog when both land in the same cycle.
            if (mul_done) begin
               rsp_result_nxt   = mul_result;
               rsp_negative_nxt = (mul_multiplier[OP_W-1] ^ mul_multiplicand[OP_W-1])
                                  & (mul_result != '0);
               rsp_timeout_nxt  = 1'b0;
               rsp_valid_nxt    = 1'b1;
               state_nxt        = RESP;
            end else if (run_cnt == RUN_CNT_W'(MAX_RUN_CYCLES - 1)) begin
               rsp_result_nxt   = '0;
               rsp_negative_nxt = 1'b0;
               rsp_timeout_nxt  = 1'b1;
               rsp_valid_nxt    = 1'b1;
               state_nxt        = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // The multiplier is held in load/clear everywhere except RUN.
      mul_start_nxt = (state_nxt != RUN);
      req_ready_nxt = (state_nxt == IDLE);
      busy_nxt      = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: table-driven bench with a behavioural shift-add
// multiplier model and a response scoreboard for mult_sequencer.
module tb_mult_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [7:0]  multiplier_in, multiplicand_in;
   logic        mul_start;
   logic [7:0]  mul_multiplier, mul_multiplicand;
   logic        mul_done;
   logic [13:0] mul_result;
   logic        rsp_valid, rsp_ready;
   logic [13:0] rsp_result;
   logic        rsp_negative, rsp_timeout, busy;

   always #5 clock = ~clock;

   mult_sequencer #(.LOAD_CYCLES(1), .MAX_RUN_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .multiplier_in(multiplier_in), .multiplicand_in(multiplicand_in),
      .mul_start(mul_start), .mul_multiplier(mul_multiplier),
      .mul_multiplicand(mul_multiplicand),
      .mul_done(mul_done), .mul_result(mul_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_negative(rsp_negative),
      .rsp_timeout(rsp_timeout), .busy(busy)
   );

   // Shift-add multiplier model: loads on mul_start, one shift per run cycle.
   logic [6:0]  m_mreg;
   logic [13:0] m_acc, m_mcand;
   logic        force_timeout;

   always @(posedge clock) begin
      if (mul_start) begin
         m_acc   <= 14'd0;
         m_mreg  <= mul_multiplier[6:0];
         m_mcand <= {7'd0, mul_multiplicand[6:0]};
      end else begin
         if (m_mreg[0]) m_acc <= m_acc + m_mcand;
         m_mreg  <= m_mreg >> 1;
         m_mcand <= m_mcand << 1;
      end
   end
   assign mul_done   = !force_timeout && ((m_mreg >> 1) == 7'd0);
   assign mul_result = m_acc + (m_mreg[0] ? m_mcand : 14'd0);

   typedef struct {
      logic [13:0] result;
      logic        neg;
      logic        to;
      int          runs;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       force_to;
      exp_t       e;
   } vec_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   run_obs = 0;
   int   accepts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: counts RUN cycles, pops the scoreboard on each response handshake.
   always @(negedge clock) begin
      if (reset) begin
         run_obs = 0;
      end else begin
         if (busy && !mul_start) run_obs++;
         if (req_valid && req_ready) accepts++;
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("rsp_result",   32'(rsp_result),   32'(e.result));
               check("rsp_negative", 32'(rsp_negative), 32'(e.neg));
               check("rsp_timeout",  32'(rsp_timeout),  32'(e.to));
               check("run_cycles",   32'(run_obs),      32'(e.runs));
            end
            run_obs = 0;
         end
      end
   end

   // Drive one request and push its expectation once it is accepted.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input exp_t e);
      bit got = 0;
      multiplier_in   = a;
      multiplicand_in = b;
      req_valid       = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clock);
         if (req_ready) begin
            sb_q.push_back(e);
            got = 1;
         end else begin
            @(posedge clock); #1;
         end
      end
      if (!got) check("req_accept_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   // Wait for rsp_valid, stall rsp_ready, then consume and check the return to IDLE.
   task automatic take_rsp(input int stall);
      bit got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clock);
         if (rsp_valid) got = 1;
      end
      if (!got) check("rsp_valid_timeout", 32'd0, 32'd1);
      for (int i = 0; i < stall; i++) @(negedge clock);
      @(posedge clock); #1;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      check("busy_after_hs",      32'(busy),      32'd0);
      check("req_ready_after_hs", 32'(req_ready), 32'd1);
      check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      logic [13:0] held_res;
      logic        held_neg, held_to;
      int          acc_before;
      bit          ok;

      vecs = '{
         '{8'h05, 8'h83, 1'b0, '{14'd15,    1'b1, 1'b0, 3}},
         '{8'h7F, 8'h7F, 1'b0, '{14'd16129, 1'b0, 1'b0, 7}},
         '{8'h80, 8'h05, 1'b0, '{14'd0,     1'b0, 1'b0, 1}},
         '{8'h03, 8'h04, 1'b0, '{14'd12,    1'b0, 1'b0, 2}},
         '{8'h03, 8'h84, 1'b0, '{14'd12,    1'b1, 1'b0, 2}},
         '{8'h01, 8'hFF, 1'b0, '{14'd127,   1'b1, 1'b0, 1}},
         '{8'h83, 8'h00, 1'b0, '{14'd0,     1'b0, 1'b0, 2}},
         '{8'hFF, 8'hFF, 1'b0, '{14'd16129, 1'b0, 1'b0, 7}},
         '{8'h00, 8'h00, 1'b0, '{14'd0,     1'b0, 1'b0, 1}},
         '{8'h05, 8'h03, 1'b1, '{14'd0,     1'b0, 1'b1, 8}}
      };

      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      multiplier_in = 8'h00; multiplicand_in = 8'h00; force_timeout = 1'b0;
      #1;
      check("reset_mul_start", 32'(mul_start), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_busy",      32'(busy),      32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_result",32'(rsp_result),32'd0);
      check("reset_operands",  32'({mul_multiplier, mul_multiplicand}), 32'd0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock); #1;

      // Table-driven vectors.
      foreach (vecs[i]) begin
         force_timeout = vecs[i].force_to;
         send(vecs[i].a, vecs[i].b, vecs[i].e);
         take_rsp(0);
         force_timeout = 1'b0;
      end

      // Response held off for 10 cycles while a second request is offered.
      send(8'h06, 8'h87, '{14'd42, 1'b1, 1'b0, 3});
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         if (rsp_valid) ok = 1;
      end
      if (!ok) check("stall_rsp_valid_timeout", 32'd0, 32'd1);
      held_res = rsp_result; held_neg = rsp_negative; held_to = rsp_timeout;
      acc_before = accepts;
      @(posedge clock); #1;
      multiplier_in = 8'h11; multiplicand_in = 8'h22; req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         check("stall_rsp_stable", 32'({rsp_result, rsp_negative, rsp_timeout}),
               32'({held_res, held_neg, held_to}));
         check("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("stall_no_accept", 32'(accepts), 32'(acc_before));
      take_rsp(0);

      // Reset in the middle of RUN discards the transaction.
      send(8'h40, 8'h02, '{14'd128, 1'b0, 1'b0, 7});
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         if (run_obs >= 2) ok = 1;
      end
      if (!ok) check("run_entry_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("midrun_rst_mul_start", 32'(mul_start), 32'd1);
      check("midrun_rst_busy",      32'(busy),      32'd0);
      check("midrun_rst_req_ready", 32'(req_ready), 32'd1);
      check("midrun_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      sb_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      ok = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (rsp_valid) ok = 0;
      end
      check("midrun_rst_no_rsp", 32'(ok), 32'd1);
      @(posedge clock); #1;
      send(8'h03, 8'h04, '{14'd12, 1'b0, 1'b0, 2});
      take_rsp(2);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
